// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW stall, branch flush, EX forwarding selects and saturating perf counters.
// Build option: define HAZARD_FWD_EN to forward into EX; otherwise any RAW dependence stalls until the writer retires.
module hazard_ctrl #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } slot_t;

    slot_t            ex, mem, wb;
    logic [REG_W-1:0] ex_rs, ex_rt;
    logic             ex_uses_rs, ex_uses_rt;
    logic             hazard;
    logic             unused;

    function automatic logic hit(slot_t s, logic [REG_W-1:0] src, logic used);
        return s.valid & s.wr & (s.rd == src) & used;
    endfunction

`ifdef HAZARD_FWD_EN
    assign hazard = id_valid & ex.is_load & (hit(ex, id_rs, id_uses_rs) | hit(ex, id_rt, id_uses_rt));
    // MEM is the younger writer, so it takes precedence over WB
    assign fwd_a  = hit(mem, ex_rs, ex_uses_rs & ex.valid) ? 2'b10 :
                    hit(wb, ex_rs, ex_uses_rs & ex.valid)  ? 2'b01 : 2'b00;
    assign fwd_b  = hit(mem, ex_rt, ex_uses_rt & ex.valid) ? 2'b10 :
                    hit(wb, ex_rt, ex_uses_rt & ex.valid)  ? 2'b01 : 2'b00;
    assign unused = ^{mem.is_load, wb.is_load};
`else
    assign hazard = id_valid & (hit(ex, id_rs, id_uses_rs) | hit(mem, id_rs, id_uses_rs) | hit(wb, id_rs, id_uses_rs) |
                                hit(ex, id_rt, id_uses_rt) | hit(mem, id_rt, id_uses_rt) | hit(wb, id_rt, id_uses_rt));
    assign fwd_a  = 2'b00;
    assign fwd_b  = 2'b00;
    assign unused = ^{ex.is_load, mem.is_load, wb.is_load, ex_rs, ex_rt, ex_uses_rs, ex_uses_rt};
`endif

    assign stall       = hazard & ~ex_branch_taken;
    assign bubble_idex = hazard | ex_branch_taken;
    assign flush_ifid  = ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex           <= '0;
            mem          <= '0;
            wb           <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_uses_rs   <= 1'b0;
            ex_uses_rt   <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            ex           <= {id_valid & ~bubble_idex, id_wr_en, id_is_load, id_rd};
            mem          <= ex;
            wb           <= mem;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_uses_rs   <= id_uses_rs;
            ex_uses_rt   <= id_uses_rt;
            stall_cycles <= stall_cycles + CNT_W'(stall & ~&stall_cycles);
            flush_count  <= flush_count + CNT_W'(ex_branch_taken & ~&flush_count);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed literal checks plus random traffic against an in-order instruction-window model.
// Follows HAZARD_FWD_EN the same way the design does.
module tb_hazard_ctrl;
    localparam int RW   = 6;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic          id_wr_en = 1'b0, id_is_load = 1'b0, ex_branch_taken = 1'b0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          stall, bubble_idex, flush_ifid;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles, flush_count;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(stall),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the three instructions beyond ID, oldest last (0=EX, 1=MEM, 2=WB)
    typedef struct {
        bit v; bit wr; bit ld; int rd; int rs; int rt; bit urs; bit urt;
    } ins_t;
    ins_t pipe[3];
    int   m_stall, m_flush;
    bit   mvalid = 1'b0;

    function automatic bit hit(ins_t s, int src, bit used);
        return s.v && s.wr && used && s.rd == src;
    endfunction

    function automatic bit src_hit(int k);
        return hit(pipe[k], int'(id_rs), id_uses_rs) || hit(pipe[k], int'(id_rt), id_uses_rt);
    endfunction

    function automatic bit m_hazard();
        if (!id_valid) return 1'b0;
        if (FWD) return pipe[0].ld && src_hit(0);
        return src_hit(0) || src_hit(1) || src_hit(2);
    endfunction

    function automatic int m_fwd(int src, bit used);
        if (!FWD || !pipe[0].v) return 0;
        if (hit(pipe[1], src, used)) return 2;
        if (hit(pipe[2], src, used)) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (pipe[k]) pipe[k] = '{default: 0};
            m_stall = 0;
            m_flush = 0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            bit hz, bub;
            hz  = m_hazard();
            bub = hz || ex_branch_taken;
            if (hz && !ex_branch_taken && m_stall < CMAX) m_stall++;
            if (ex_branch_taken && m_flush < CMAX) m_flush++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v: id_valid && !bub, wr: id_wr_en, ld: id_is_load, rd: int'(id_rd),
                        rs: int'(id_rs), rt: int'(id_rt), urs: id_uses_rs, urt: id_uses_rt};
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            bit hz;
            hz = m_hazard();
            chk("m_stall", int'(stall), int'(hz && !ex_branch_taken));
            chk("m_bubble", int'(bubble_idex), int'(hz || ex_branch_taken));
            chk("m_flush", int'(flush_ifid), int'(ex_branch_taken));
            chk("m_fwd_a", int'(fwd_a), m_fwd(pipe[0].rs, pipe[0].urs));
            chk("m_fwd_b", int'(fwd_b), m_fwd(pipe[0].rt, pipe[0].urt));
            chk("m_stall_cycles", int'(stall_cycles), m_stall);
            chk("m_flush_count", int'(flush_count), m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int rs, int rt, bit urs, bit urt, int rd, bit wr, bit ld, bit br);
        id_valid        = v;
        id_rs           = RW'(rs);
        id_rt           = RW'(rt);
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        id_rd           = RW'(rd);
        id_wr_en        = wr;
        id_is_load      = ld;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset held with a live, self-dependent load in ID
        drive(1, 5, 5, 1, 1, 5, 1, 1, 0);
        tick();
        tick();
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_bubble", int'(bubble_idex), 0);
        chk("rst_flush", int'(flush_ifid), 0);
        chk("rst_fwd_a", int'(fwd_a), 0);
        chk("rst_fwd_b", int'(fwd_b), 0);
        chk("rst_stall_cycles", int'(stall_cycles), 0);
        chk("rst_flush_count", int'(flush_count), 0);
        rst = 1'b0;
        idle();
        tick();

`ifdef HAZARD_FWD_EN
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 5, 0, 1, 0, 9, 1, 0, 0); #1;
        chk("alu_no_stall", int'(stall), 0);
        tick();
        idle(); #1;
        chk("fwd_a_from_mem", int'(fwd_a), 2);
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 5, 0, 1, 8, 1, 0, 0); tick();
        idle(); #1;
        chk("fwd_b_from_wb", int'(fwd_b), 1);
        chk("fwd_a_unused_rs", int'(fwd_a), 0);
        tick();

        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
        drive(1, 7, 0, 1, 0, 9, 1, 0, 0); #1;
        chk("lu_stall", int'(stall), 1);
        chk("lu_bubble", int'(bubble_idex), 1);
        tick(); #1;
        chk("lu_stall_once", int'(stall), 0);
        tick();
        idle(); #1;
        chk("lu_fwd_a_wb", int'(fwd_a), 1);
        chk("lu_stall_cycles", int'(stall_cycles), 1);
        tick();
`else
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        drive(1, 3, 0, 1, 0, 9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_stall_hold", int'(stall), 1);
            chk("raw_fwd_a_zero", int'(fwd_a), 0);
            chk("raw_fwd_b_zero", int'(fwd_b), 0);
            tick();
        end
        #1;
        chk("raw_stall_release", int'(stall), 0);
        tick();
        idle(); #1;
        chk("raw_stall_cycles", int'(stall_cycles), 3);
        tick();
`endif

        // taken branch coinciding with a load-use match
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
        drive(1, 7, 0, 1, 0, 9, 1, 0, 1); #1;
        chk("br_stall", int'(stall), 0);
        chk("br_bubble", int'(bubble_idex), 1);
        chk("br_flush", int'(flush_ifid), 1);
        tick();
        idle(); #1;
        chk("br_flush_count", int'(flush_count), 1);
        chk("br_stall_cycles", int'(stall_cycles), 0);
        tick();

        // reset during a stall
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
        drive(1, 7, 0, 1, 0, 9, 1, 0, 0); #1;
        chk("mid_stall_pre", int'(stall), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_stall_cleared", int'(stall), 0);
        chk("mid_stall_counter", int'(stall_cycles), 0);
        chk("mid_flush_counter", int'(flush_count), 0);
        idle();
        tick();

        // counter saturation
        do_reset();
        drive(1, 1, 0, 1, 0, 1, 1, 1, 0);
        repeat (700) tick();
        #1;
        chk("stall_sat", int'(stall_cycles), CMAX);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (CMAX) tick();
        #1;
        chk("flush_at_max", int'(flush_count), CMAX);
        repeat (6) tick();
        #1;
        chk("flush_sat", int'(flush_count), CMAX);

        // random traffic over a small register range to provoke hazards
        do_reset();
        repeat (600) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            tick();
        end
        idle();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
